seg7_scan_driver: RTL and testbench

//  Time-multiplexed N-digit 7-segment display driver; successor to the single-digit decoder.

---
 rtl/seg7_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment scan driver with double-buffered display image.
// Define SEG7_LZ_BLANK_EN to enable leading-zero suppression on the active image.
module seg7_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_tick
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] GUARD_END  = PRESC_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);

  logic [PRESC_W-1:0]    presc_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic                  boundary;
  logic                  pending;
  logic [4*N_DIGITS-1:0] shadow_data;
  logic [N_DIGITS-1:0]   shadow_blank;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [4*N_DIGITS-1:0] act_data;
  logic [N_DIGITS-1:0]   act_blank;
  logic [N_DIGITS-1:0]   act_dp;
  logic [N_DIGITS-1:0]   lz_mask;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [N_DIGITS-1:0]   an_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      4'hF: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Stage p0: scan counters and the shadow/active display image
  assign boundary = (presc_p0 == PRESC_LAST) && (idx_p0 == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_p0 <= '0;
      idx_p0   <= '0;
    end else if (presc_p0 == PRESC_LAST) begin
      presc_p0 <= '0;
      idx_p0   <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
    end else begin
      presc_p0 <= presc_p0 + 1'b1;
    end
  end

  // A load on the boundary cycle re-arms pending so the new image lands one frame later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending      <= 1'b0;
      shadow_data  <= '0;
      shadow_blank <= '0;
      shadow_dp    <= '0;
      act_data     <= '0;
      act_blank    <= '1;
      act_dp       <= '0;
    end else begin
      if (boundary && pending) begin
        act_data  <= shadow_data;
        act_blank <= shadow_blank;
        act_dp    <= shadow_dp;
        pending   <= 1'b0;
      end
      if (load) begin
        shadow_data  <= data;
        shadow_blank <= blank_mask;
        shadow_dp    <= dp_in;
        pending      <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic lz_run;

  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (act_data[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (presc_p0 >= GUARD_END) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_p0 == IDX_W'(i) && !act_blank[i]) begin
          if (!lz_mask[i]) begin
            an_d[i] = 1'b0;
            seg_d   = hex_to_seg(act_data[4*i +: 4]);
            dp_d    = ~act_dp[i];
          end else if (act_dp[i]) begin
            an_d[i] = 1'b0;
            dp_d    = 1'b0;
          end
        end
      end
    end
  end

  // Stage p1: registered pin drivers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (N_DIGITS=4, SCAN_DIV=4, GUARD_CYCLES=1).
// Build with +define+SEG7_LZ_BLANK_EN to exercise leading-zero suppression expectations.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(
    .N_DIGITS    (4),
    .SCAN_DIV    (4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (data),
    .blank_mask(blank_mask),
    .dp_in     (dp_in),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] m, input logic [3:0] dp);
    load = 1'b1; data = d; blank_mask = m; dp_in = dp;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance to the next negedge where frame_tick is high, bounded.
  task automatic wait_tick(input string tag);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk(tag, 0, {31'd0, seen}, 32'd1);
  endtask

  // Called on a tick negedge; samples the 16 following negedges as one whole frame.
  // lit[d]=1: anode d drives low during its visible slot; segs[7d+:7], dpn[d] are its pins.
  task automatic check_frame(input string tag, input logic [27:0] segs,
                             input logic [3:0] lit, input logic [3:0] dpn);
    logic [12:0] exp;
    logic [3:0]  an_e;
    int d, p;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      d = (j - 1) / 4;
      p = (j - 1) % 4;
      if (p == 0 || !lit[d]) exp = {(j == 16), 4'hF, 7'h7F, 1'b1};
      else begin
        an_e    = 4'hF;
        an_e[d] = 1'b0;
        exp = {(j == 16), an_e, segs[7*d +: 7], dpn[d]};
      end
      chk(tag, j, {19'd0, frame_tick, an_n, seg_n, dp_n}, {19'd0, exp});
    end
  endtask

  initial begin
    bit any_low;
    int n;
    rst_n = 1'b0; load = 1'b0; data = '0; blank_mask = '0; dp_in = '0;

    // 1: reset values and blank display until the first load
    repeat (3) @(negedge clk);
    chk("t1_reset", 0, {19'd0, frame_tick, an_n, seg_n, dp_n}, {19'd0, 1'b0, 4'hF, 7'h7F, 1'b1});
    rst_n = 1'b1;
    any_low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (an_n !== 4'hF) any_low = 1;
    end
    chk("t1_no_anode", 0, {31'd0, any_low}, 32'd0);

    // 2: basic image 3A9F, dp on digit 2
    wait_tick("t2_sync");
    do_load(16'h3A9F, 4'b0000, 4'b0100);
    wait_tick("t2_tick");
    check_frame("t2_frame", {7'h30, 7'h08, 7'h10, 7'h0E}, 4'b1111, 4'b1011);

    // 3a: two loads in one frame, last wins
    do_load(16'h1111, 4'b0000, 4'b0000);
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_tick("t3a_tick");
    check_frame("t3a_frame", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111, 4'b1111);

    // 3b: load on the boundary cycle shows the old shadow first
    @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (13) @(negedge clk);
    do_load(16'h7777, 4'b0000, 4'b0000);
    chk("t3b_tick", 0, {31'd0, frame_tick}, 32'd1);
    check_frame("t3b_old", {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111, 4'b1111);
    check_frame("t3b_new", {7'h78, 7'h78, 7'h78, 7'h78}, 4'b1111, 4'b1111);

    // 4: blank mask 1010, dp on digits 0,1,3
    do_load(16'h8642, 4'b1010, 4'b1011);
    wait_tick("t4_tick");
    check_frame("t4_frame", {7'h7F, 7'h02, 7'h7F, 7'h24}, 4'b0101, 4'b1110);

    // decode coverage: b C d E and 8 4 7 6
    do_load(16'hBCDE, 4'b0000, 4'b0000);
    wait_tick("dec1_tick");
    check_frame("dec1_frame", {7'h03, 7'h46, 7'h21, 7'h06}, 4'b1111, 4'b1111);
    do_load(16'h8476, 4'b0000, 4'b0000);
    wait_tick("dec2_tick");
    check_frame("dec2_frame", {7'h00, 7'h19, 7'h78, 7'h02}, 4'b1111, 4'b1111);

    // 5: leading zeros (suppressed only with the macro defined)
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_tick("t5a_tick");
`ifdef SEG7_LZ_BLANK_EN
    check_frame("t5a_frame", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0011, 4'b1111);
`else
    check_frame("t5a_frame", {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111, 4'b1111);
`endif
    do_load(16'h0000, 4'b0000, 4'b0100);
    wait_tick("t5b_tick");
`ifdef SEG7_LZ_BLANK_EN
    check_frame("t5b_frame", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0101, 4'b1011);
`else
    check_frame("t5b_frame", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b1011);
`endif

    // 6: one-cycle reset in the middle of digit 2's slot
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset", 0, {19'd0, frame_tick, an_n, seg_n, dp_n}, {19'd0, 1'b0, 4'hF, 7'h7F, 1'b1});
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (frame_tick === 1'b1) break;
    end
    chk("t6_restart", 0, n, 32'd16);
    check_frame("t6_blank", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
